// File: rtl/mult_8bit.sv
// 8x8 unsigned carry-ripple array multiplier, registered at input and output.
// Define MULT8_PIPE_EN to add a pipeline register after array row 4 (latency 3 instead of 2).

module mult8_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module mult8_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module mult_8bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  output logic [15:0] p
);

  logic [7:0]      a_r, b_r;
  logic            v0;

  // row_s[j] is the 8-bit sum leaving row j, row_c[j] its carry out
  logic [7:0][7:0] row_s;
  logic [7:0]      row_c;

  logic [7:1]      s4_use;
  logic            c4_use;
  logic [7:0]      a_hi;
  logic [2:0]      b_hi;
  logic [4:0]      lo_use;
  logic            v_last;
  logic [15:0]     p_arr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= 8'h00;
      b_r <= 8'h00;
      v0  <= 1'b0;
    end else begin
      v0 <= in_valid;
      if (in_valid) begin
        a_r <= a;
        b_r <= b;
      end
    end
  end

`ifdef MULT8_PIPE_EN
  logic [7:1] s4_r;
  logic       c4_r;
  logic [7:0] a_p;
  logic [2:0] b_p;
  logic [4:0] lo_r;
  logic       v1;

  // mid-array register: partial sum of rows 0..4, operands still needed, finished low bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s4_r <= 7'h00;
      c4_r <= 1'b0;
      a_p  <= 8'h00;
      b_p  <= 3'h0;
      lo_r <= 5'h00;
      v1   <= 1'b0;
    end else begin
      v1 <= v0;
      if (v0) begin
        s4_r <= row_s[4][7:1];
        c4_r <= row_c[4];
        a_p  <= a_r;
        b_p  <= b_r[7:5];
        lo_r <= {row_s[4][0], row_s[3][0], row_s[2][0], row_s[1][0], row_s[0][0]};
      end
    end
  end

  assign s4_use = s4_r;
  assign c4_use = c4_r;
  assign a_hi   = a_p;
  assign b_hi   = b_p;
  assign lo_use = lo_r;
  assign v_last = v1;
`else
  assign s4_use = row_s[4][7:1];
  assign c4_use = row_c[4];
  assign a_hi   = a_r;
  assign b_hi   = b_r[7:5];
  assign lo_use = {row_s[4][0], row_s[3][0], row_s[2][0], row_s[1][0], row_s[0][0]};
  assign v_last = v0;
`endif

  assign row_s[0] = a_r & {8{b_r[0]}};
  assign row_c[0] = 1'b0;

  // each row adds pp row j to the previous row's sum shifted right by one
  for (genvar j = 1; j < 8; j++) begin : g_row
    logic [7:0] x;
    logic [7:0] y;
    logic [8:1] cy;

    if (j < 5) begin : g_lo_op
      assign x = a_r & {8{b_r[j]}};
    end else begin : g_hi_op
      assign x = a_hi & {8{b_hi[j-5]}};
    end

    if (j == 5) begin : g_y_mid
      assign y = {c4_use, s4_use};
    end else begin : g_y_chain
      assign y = {row_c[j-1], row_s[j-1][7:1]};
    end

    mult8_ha u_ha (
      .x (x[0]),
      .y (y[0]),
      .s (row_s[j][0]),
      .c (cy[1])
    );

    for (genvar i = 1; i < 8; i++) begin : g_bit
      mult8_fa u_fa (
        .x  (x[i]),
        .y  (y[i]),
        .ci (cy[i]),
        .s  (row_s[j][i]),
        .co (cy[i+1])
      );
    end

    assign row_c[j] = cy[8];
  end

  assign p_arr = {row_c[7], row_s[7], row_s[6][0], row_s[5][0], lo_use};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p         <= 16'h0000;
    end else begin
      out_valid <= v_last;
      if (v_last) begin
        p <= p_arr;
      end
    end
  end

endmodule

// File: tb/tb_mult_8bit.sv
// Directed and exhaustive checks for mult_8bit; honours MULT8_PIPE_EN for the latency.

module tb_mult_8bit;

`ifdef MULT8_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic [15:0] p;

  int checks;
  int errors;

  mult_8bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .p         (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = 8'h00;
    b = 8'h00;
    #12;
    checks++;
    if (out_valid !== 1'b0 || p !== 16'h0000) begin
      errors++;
      $display("FAIL reset_hold: out_valid=%b p=%h, want 0/0000", out_valid, p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || p !== 16'h0000) begin
        errors++;
        $display("FAIL reset_release[%0d]: out_valid=%b p=%h, want 0/0000", k, out_valid, p);
      end
    end
  endtask

  task automatic test_single(input logic [7:0] xa, input logic [7:0] xb, input logic [15:0] exp);
    in_valid = 1'b1;
    a = xa;
    b = xb;
    tick();
    in_valid = 1'b0;
    a = 8'h5a;
    b = 8'ha5;
    for (int k = 1; k < LAT; k++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_early %0d*%0d: out_valid=%b at edge %0d, want 0", xa, xb, out_valid, k);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || p !== exp) begin
      errors++;
      $display("FAIL single %0d*%0d: out_valid=%b p=%0d, want 1/%0d", xa, xb, out_valid, p, exp);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || p !== exp) begin
      errors++;
      $display("FAIL single_after %0d*%0d: out_valid=%b p=%0d, want 0/%0d", xa, xb, out_valid, p, exp);
    end
  endtask

  task automatic test_stream();
    logic [7:0]  sa [6] = '{8'd6, 8'd15, 8'd10, 8'd13, 8'd5, 8'd8};
    logic [7:0]  sb [6] = '{8'd2, 8'd15, 8'd9, 8'd15, 8'd9, 8'd13};
    logic [15:0] se [6] = '{16'd12, 16'd225, 16'd90, 16'd195, 16'd45, 16'd104};
    for (int i = 0; i < 6 + LAT - 1; i++) begin
      in_valid = (i < 6);
      a = (i < 6) ? sa[i] : 8'h00;
      b = (i < 6) ? sb[i] : 8'h00;
      tick();
      if (i >= LAT - 1) begin
        checks++;
        if (out_valid !== 1'b1 || p !== se[i-LAT+1]) begin
          errors++;
          $display("FAIL stream[%0d]: out_valid=%b p=%0d, want 1/%0d", i - LAT + 1, out_valid, p, se[i-LAT+1]);
        end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_gap();
    logic        gv [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0]  ga [3] = '{8'd3, 8'd99, 8'd7};
    logic [7:0]  gb [3] = '{8'd4, 8'd99, 8'd11};
    logic [15:0] ge [3] = '{16'd12, 16'd12, 16'd77};
    for (int i = 0; i < 3 + LAT - 1; i++) begin
      in_valid = (i < 3) ? gv[i] : 1'b0;
      a = (i < 3) ? ga[i] : 8'h00;
      b = (i < 3) ? gb[i] : 8'h00;
      tick();
      if (i >= LAT - 1) begin
        checks++;
        if (out_valid !== gv[i-LAT+1] || p !== ge[i-LAT+1]) begin
          errors++;
          $display("FAIL gap[%0d]: out_valid=%b p=%0d, want %b/%0d", i - LAT + 1, out_valid, p, gv[i-LAT+1], ge[i-LAT+1]);
        end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_inflight();
    in_valid = 1'b1;
    a = 8'd50;
    b = 8'd60;
    tick();
    a = 8'd70;
    b = 8'd80;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || p !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async: out_valid=%b p=%h, want 0/0000", out_valid, p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || p !== 16'h0000) begin
        errors++;
        $display("FAIL reset_drop[%0d]: out_valid=%b p=%h, want 0/0000", k, out_valid, p);
      end
    end
  endtask

  task automatic test_sweep();
    logic [15:0] q [$];
    logic [15:0] e;
    int n_out;
    int budget;
    n_out = 0;
    budget = 0;
    for (int i = 0; i < 65536; i++) begin
      in_valid = 1'b1;
      a = i[15:8];
      b = i[7:0];
      q.push_back(16'(i[15:8] * i[7:0]));
      tick();
      if (out_valid) begin
        n_out++;
        e = q.pop_front();
        checks++;
        if (p !== e) begin
          errors++;
          if (errors < 20) $display("FAIL sweep #%0d: p=%0d, want %0d", n_out - 1, p, e);
        end
      end
    end
    in_valid = 1'b0;
    while (q.size() > 0 && budget < LAT + 4) begin
      tick();
      budget++;
      if (out_valid) begin
        n_out++;
        e = q.pop_front();
        checks++;
        if (p !== e) begin
          errors++;
          if (errors < 20) $display("FAIL sweep #%0d: p=%0d, want %0d", n_out - 1, p, e);
        end
      end
    end
    checks++;
    if (n_out !== 65536) begin
      errors++;
      $display("FAIL sweep_count: got %0d outputs, want 65536", n_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single(8'd129, 8'd255, 16'd32895);
    test_single(8'd204, 8'd170, 16'd34680);
    test_single(8'd135, 8'd227, 16'd30645);
    test_single(8'd192, 8'd7,   16'd1344);
    test_single(8'd255, 8'd255, 16'd65025);
    test_single(8'd0,   8'd200, 16'd0);
    test_single(8'd1,   8'd173, 16'd173);
    test_single(8'd128, 8'd2,   16'd256);
    test_stream();
    test_gap();
    test_reset_inflight();
    test_single(8'd17, 8'd19, 16'd323);
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
